// File: rtl/led_row_scanner.sv
// Row sequencer for the 8-row LED matrix: fetch a row pattern, blank the columns,
// then light the row for a fixed dwell. All outputs are registered.
module led_row_scanner #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    output logic [3:0] ROW_SEL,
    output logic [7:0] COL_OUT,
    output logic       ROW_REQ,
    output logic [2:0] ROW_ADDR,
    input  logic [7:0] ROW_DATA,
    input  logic       ROW_VALID,
    output logic       FRAME_DONE,
    output logic       BUSY
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    // Counter runs 0..CNT_MAX-1
    localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;
    localparam logic [1:0] SHOW  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [2:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    sel_d;
    logic          fd_d;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sel_d   = ROW_SEL;
        fd_d    = 1'b0;
        // Dropping ENABLE wins over everything, including a same-edge ROW_VALID
        if (state_q != IDLE && !ENABLE) begin
            state_d = IDLE;
            r_d     = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ENABLE) begin
                        state_d = FETCH;
                        r_d     = 3'd0;
                    end
                end
                FETCH: begin
                    if (ROW_VALID) begin
                        data_d  = ROW_DATA;
                        sel_d   = {1'b0, r_q};
                        cnt_d   = '0;
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d   = '0;
                        r_d     = r_q + 3'd1;
                        fd_d    = (r_q == 3'd7);
                        state_d = FETCH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            r_q        <= 3'd0;
            cnt_q      <= '0;
            data_q     <= 8'd0;
            ROW_SEL    <= 4'd0;
            COL_OUT    <= 8'd0;
            ROW_REQ    <= 1'b0;
            ROW_ADDR   <= 3'd0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ROW_SEL    <= sel_d;
            COL_OUT    <= (state_d == SHOW) ? data_d : 8'd0;
            ROW_REQ    <= (state_d == FETCH);
            ROW_ADDR   <= r_d;
            FRAME_DONE <= fd_d;
            BUSY       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_led_row_scanner.sv
// Directed bench for led_row_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2; expected
// outputs are queued per cycle and compared 1 time unit after each rising edge.
module tb_led_row_scanner;

    logic       CLK;
    logic       RESET_N;
    logic       ENABLE;
    logic [3:0] ROW_SEL;
    logic [7:0] COL_OUT;
    logic       ROW_REQ;
    logic [2:0] ROW_ADDR;
    logic [7:0] ROW_DATA;
    logic       ROW_VALID;
    logic       FRAME_DONE;
    logic       BUSY;

    logic       use_auto;
    logic [7:0] man_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] tag;
        logic [7:0]  col;
        logic        req;
        logic [2:0]  addr;
        logic [3:0]  sel;
        logic        fd;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    led_row_scanner #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .ROW_SEL   (ROW_SEL),
        .COL_OUT   (COL_OUT),
        .ROW_REQ   (ROW_REQ),
        .ROW_ADDR  (ROW_ADDR),
        .ROW_DATA  (ROW_DATA),
        .ROW_VALID (ROW_VALID),
        .FRAME_DONE(FRAME_DONE),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb ROW_DATA = use_auto ? (8'hA0 + {5'd0, ROW_ADDR}) : man_data;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input logic [63:0] tag, input string what,
                         input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %0s %0s observed=%h expected=%h", tag, what, got, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] tag, input logic [7:0] col, input logic req,
                            input logic [2:0] addr, input logic [3:0] sel, input logic fd,
                            input logic busy);
        exp_t e;
        e.tag  = tag;
        e.col  = col;
        e.req  = req;
        e.addr = addr;
        e.sel  = sel;
        e.fd   = fd;
        e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            check(e.tag, "COL_OUT", COL_OUT, e.col);
            check(e.tag, "ROW_REQ", {7'd0, ROW_REQ}, {7'd0, e.req});
            if (e.req) check(e.tag, "ROW_ADDR", {5'd0, ROW_ADDR}, {5'd0, e.addr});
            check(e.tag, "ROW_SEL", {4'd0, ROW_SEL}, {4'd0, e.sel});
            check(e.tag, "FRAME_DONE", {7'd0, FRAME_DONE}, {7'd0, e.fd});
            check(e.tag, "BUSY", {7'd0, BUSY}, {7'd0, e.busy});
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        pop_compare();
    endtask

    // Free-running scan: cycle k counts from the first FETCH; each row is 7 cycles
    task automatic scan_expect(input int k);
        int p;
        int row;
        logic [2:0] r3;
        logic [2:0] prev;
        p    = k % 7;
        row  = (k / 7) % 8;
        r3   = row[2:0];
        prev = r3 - 3'd1;
        if (p == 0)
            push_exp("scan", 8'h00, 1'b1, r3, (k == 0) ? 4'd0 : {1'b0, prev},
                     (k > 0 && row == 0), 1'b1);
        else if (p < 3)
            push_exp("scan", 8'h00, 1'b0, r3, {1'b0, r3}, 1'b0, 1'b1);
        else
            push_exp("scan", 8'hA0 + {5'd0, r3}, 1'b0, r3, {1'b0, r3}, 1'b0, 1'b1);
    endtask

    initial begin
        RESET_N   = 1'b0;
        ENABLE    = 1'b0;
        ROW_VALID = 1'b1;
        use_auto  = 1'b1;
        man_data  = 8'h00;
        #1;
        push_exp("reset", 8'h00, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        pop_compare();
        #1;
        RESET_N = 1'b1;

        for (int i = 0; i < 2; i++) begin
            push_exp("idle", 8'h00, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
            step();
        end

        // Free-running scan over two full frames, into BLANK of row 5 of the third
        ENABLE = 1'b1;
        for (int k = 0; k <= 148; k++) begin
            if (k == 25) begin
                use_auto = 1'b0;
                man_data = 8'hFF;
            end else begin
                use_auto = 1'b1;
            end
            scan_expect(k);
            step();
        end
        use_auto = 1'b1;

        // ENABLE drop during BLANK of row 5
        ENABLE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_exp("drop", 8'h00, 1'b0, 3'd0, 4'd5, 1'b0, 1'b0);
            step();
        end
        ENABLE    = 1'b1;
        ROW_VALID = 1'b0;
        push_exp("drop", 8'h00, 1'b1, 3'd0, 4'd5, 1'b0, 1'b1);
        step();

        // ENABLE falls on the edge ROW_VALID would be accepted
        ENABLE    = 1'b0;
        ROW_VALID = 1'b1;
        use_auto  = 1'b0;
        man_data  = 8'hE7;
        push_exp("simul", 8'h00, 1'b0, 3'd0, 4'd5, 1'b0, 1'b0);
        step();
        ENABLE   = 1'b1;
        use_auto = 1'b1;
        push_exp("simul", 8'h00, 1'b1, 3'd0, 4'd5, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 2; i++) begin
            push_exp("simul", 8'h00, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            push_exp("simul", 8'hA0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
            step();
        end

        // Asynchronous reset mid-SHOW, away from any clock edge
        #2;
        RESET_N = 1'b0;
        #1;
        push_exp("arst", 8'h00, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        pop_compare();
        @(negedge CLK);
        RESET_N = 1'b1;

        // Slow handshake: ROW_VALID arrives after 5 cycles of ROW_REQ
        ROW_VALID = 1'b0;
        use_auto  = 1'b0;
        man_data  = 8'h11;
        for (int i = 0; i < 5; i++) begin
            push_exp("slow", 8'h00, 1'b1, 3'd0, 4'd0, 1'b0, 1'b1);
            step();
        end
        ROW_VALID = 1'b1;
        man_data  = 8'h3C;
        push_exp("slow", 8'h00, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
        step();
        ROW_VALID = 1'b0;
        man_data  = 8'h77;
        push_exp("slow", 8'h00, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            push_exp("slow", 8'h3C, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            push_exp("slow", 8'h00, 1'b1, 3'd1, 4'd0, 1'b0, 1'b1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
